// File: rtl/sobel_frame_loader.sv
// Streams one raster-ordered frame into the Sobel core's frame buffer, then
// launches the core and reports completion with a one-cycle ap_done pulse.
module sobel_frame_loader #(
  parameter int X_BITS = 9,
  parameter int Y_BITS = 9
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ap_start,
  output logic                     ap_idle,
  output logic                     ap_done,
  input  logic [7:0]               s_tdata,
  input  logic                     s_tvalid,
  output logic                     s_tready,
  input  logic                     s_tlast,
  output logic [X_BITS+Y_BITS-1:0] indata_address0,
  output logic                     indata_ce0,
  output logic                     indata_we0,
  output logic [7:0]               indata_d0,
  output logic                     core_start,
  input  logic                     core_done,
  output logic                     err_tlast
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [X_BITS-1:0] col_r;
  logic [Y_BITS-1:0] row_r;
  logic              err_r;
  logic              accept_s;
  logic              col_max_s;
  logic              row_max_s;
  logic              frame_start_s;

  assign accept_s      = s_tvalid & (state_r == LOAD);
  assign col_max_s     = (col_r == {X_BITS{1'b1}});
  assign row_max_s     = (row_r == {Y_BITS{1'b1}});
  assign frame_start_s = (state_r == IDLE) & ap_start;

  // State register; reset abandons any frame in flight.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; the last pixel of the frame hands control to the core.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s && col_max_s && row_max_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      RUN: begin
        if (core_done) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Raster position and sticky line-length error; wrap of col carries into row.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      col_r <= {X_BITS{1'b0}};
      row_r <= {Y_BITS{1'b0}};
      err_r <= 1'b0;
    end else if (frame_start_s) begin
      col_r <= {X_BITS{1'b0}};
      row_r <= {Y_BITS{1'b0}};
      err_r <= 1'b0;
    end else if (accept_s) begin
      col_r <= col_r + X_BITS'(1);
      if (col_max_s) begin
        row_r <= row_r + Y_BITS'(1);
      end
      if (s_tlast != col_max_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Frame-buffer write port is a zero-latency pass-through of the accepted beat.
  assign indata_ce0      = accept_s;
  assign indata_we0      = accept_s;
  assign indata_d0       = accept_s ? s_tdata : 8'd0;
  assign indata_address0 = {row_r, col_r};

  assign s_tready   = (state_r == LOAD);
  assign ap_idle    = (state_r == IDLE);
  assign core_start = (state_r == RUN);
  assign ap_done    = (state_r == DONE);
  assign err_tlast  = err_r;

endmodule

// File: tb/tb_sobel_frame_loader.sv
// Self-checking bench for sobel_frame_loader on a 4x2 image: table-driven
// gapped frame, tlast error, held ap_start, spurious core_done and async reset.
module tb_sobel_frame_loader;

  localparam int XB   = 2;
  localparam int YB   = 1;
  localparam int NPIX = 8;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic             ap_start;
  logic             ap_idle;
  logic             ap_done;
  logic [7:0]       s_tdata;
  logic             s_tvalid;
  logic             s_tready;
  logic             s_tlast;
  logic [XB+YB-1:0] indata_address0;
  logic             indata_ce0;
  logic             indata_we0;
  logic [7:0]       indata_d0;
  logic             core_start;
  logic             core_done;
  logic             err_tlast;

  always #5 ap_clk = ~ap_clk;

  sobel_frame_loader #(.X_BITS(XB), .Y_BITS(YB)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_idle(ap_idle),
    .ap_done(ap_done), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .indata_address0(indata_address0), .indata_ce0(indata_ce0),
    .indata_we0(indata_we0), .indata_d0(indata_d0), .core_start(core_start),
    .core_done(core_done), .err_tlast(err_tlast)
  );

  typedef struct packed {
    logic [XB+YB-1:0] a;
    logic [7:0]       d;
  } wr_t;

  typedef struct {
    logic             tvalid;
    logic             tlast;
    logic [7:0]       tdata;
    logic             exp_we;
    logic [XB+YB-1:0] exp_addr;
  } vec_t;

  wr_t  sb[$];
  vec_t tbl[15];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_write(input logic exp_we);
    wr_t e;
    chk("ce0", indata_ce0, exp_we);
    chk("we0", indata_we0, exp_we);
    if (indata_ce0 === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty scoreboard", indata_address0, indata_d0);
      end else begin
        e = sb.pop_front();
        chk("addr", indata_address0, e.a);
        chk("data", indata_d0, e.d);
      end
    end
  endtask

  task automatic start_frame();
    @(posedge ap_clk); #1;
    ap_start = 1'b1;
    @(negedge ap_clk);
    chk("idle_before_start", ap_idle, 1'b1);
    chk("tready_idle", s_tready, 1'b0);
  endtask

  task automatic send_frame(input int err_pix, input int spur_pix, input logic hold);
    for (int p = 0; p < NPIX; p++) begin
      @(posedge ap_clk); #1;
      ap_start  = hold;
      s_tvalid  = 1'b1;
      s_tdata   = 8'($urandom_range(0, 255));
      s_tlast   = ((p % 4) == 3) ^ (p == err_pix);
      core_done = (p == spur_pix);
      sb.push_back(wr_t'{a: (XB+YB)'(p), d: s_tdata});
      @(negedge ap_clk);
      chk("tready_load", s_tready, 1'b1);
      chk("core_start_load", core_start, 1'b0);
      check_write(1'b1);
      if (p == 0) chk("err_cleared_on_start", err_tlast, 1'b0);
    end
  endtask

  task automatic run_core(input int n, input logic exp_err);
    for (int k = 1; k <= n; k++) begin
      @(posedge ap_clk); #1;
      s_tvalid  = 1'b0;
      s_tlast   = 1'b0;
      core_done = (k == n);
      @(negedge ap_clk);
      chk("core_start_run", core_start, 1'b1);
      chk("ap_done_run", ap_done, 1'b0);
      chk("tready_run", s_tready, 1'b0);
      chk("err_run", err_tlast, exp_err);
      check_write(1'b0);
    end
    @(posedge ap_clk); #1;
    core_done = 1'b0;
    ap_start  = 1'b0;
    @(negedge ap_clk);
    chk("core_start_done", core_start, 1'b0);
    chk("ap_done_pulse", ap_done, 1'b1);
    chk("err_done", err_tlast, exp_err);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    chk("ap_done_single", ap_done, 1'b0);
    chk("idle_after_done", ap_idle, 1'b1);
    chk("err_idle", err_tlast, exp_err);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 15; i++) begin
      if ((i % 2) == 0) begin
        tbl[i] = '{tvalid: 1'b1, tlast: ((i / 2) % 4) == 3, tdata: 8'(8'h30 + i / 2),
                   exp_we: 1'b1, exp_addr: (XB+YB)'(i / 2)};
      end else begin
        tbl[i] = '{tvalid: 1'b0, tlast: 1'b0, tdata: 8'hEE, exp_we: 1'b0, exp_addr: '0};
      end
    end

    ap_rst = 1'b1; ap_start = 1'b0; s_tdata = 8'd0; s_tvalid = 1'b0;
    s_tlast = 1'b0; core_done = 1'b0;
    #2;
    chk("rst_idle", ap_idle, 1'b1);
    chk("rst_done", ap_done, 1'b0);
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_core_start", core_start, 1'b0);
    chk("rst_ce0", indata_ce0, 1'b0);
    chk("rst_we0", indata_we0, 1'b0);
    chk("rst_d0", indata_d0, 8'd0);
    chk("rst_addr", indata_address0, 3'd0);
    chk("rst_err", err_tlast, 1'b0);
    #20;
    ap_rst = 1'b0;

    // Frame A: valid toggling 1/0, table-driven
    start_frame();
    for (int i = 0; i < 15; i++) begin
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      s_tvalid = tbl[i].tvalid;
      s_tlast  = tbl[i].tlast;
      s_tdata  = tbl[i].tdata;
      if (tbl[i].tvalid) sb.push_back(wr_t'{a: tbl[i].exp_addr, d: tbl[i].tdata});
      @(negedge ap_clk);
      chk("tready_tbl", s_tready, 1'b1);
      check_write(tbl[i].exp_we);
    end
    run_core(10, 1'b0);
    chk("sb_drained_a", sb.size(), 0);

    // Frame B: tlast on col 1, ap_start held, spurious core_done in LOAD
    start_frame();
    send_frame(1, 4, 1'b1);
    run_core(3, 1'b1);

    // Frame C: next start clears error; async reset at beat 3
    start_frame();
    for (int p = 0; p < 4; p++) begin
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = 8'(8'h80 + p);
      s_tlast  = 1'b0;
      if (p < 3) begin
        sb.push_back(wr_t'{a: (XB+YB)'(p), d: s_tdata});
        @(negedge ap_clk);
        check_write(1'b1);
        if (p == 0) chk("err_cleared_on_start", err_tlast, 1'b0);
      end else begin
        #1 ap_rst = 1'b1;
        #1;
        chk("async_rst_tready", s_tready, 1'b0);
        chk("async_rst_idle", ap_idle, 1'b1);
        chk("async_rst_ce0", indata_ce0, 1'b0);
        chk("async_rst_addr", indata_address0, 3'd0);
        #1 ap_rst = 1'b0;
      end
    end
    @(posedge ap_clk); #1;
    s_tvalid = 1'b0;
    @(negedge ap_clk);
    chk("idle_after_rst", ap_idle, 1'b1);
    check_write(1'b0);

    // Frame D: restarts from address 0 after the abandoned frame
    start_frame();
    send_frame(NPIX, NPIX, 1'b0);
    run_core(1, 1'b0);
    chk("sb_drained_end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_frame_loader.md
SOBEL_FRAME_LOADER -- requirements
Module: sobel_frame_loader

Interface
REQ-001 SHALL have parameter X_BITS, default 9, column index width; image width is 2^X_BITS.
REQ-002 SHALL have parameter Y_BITS, default 9, row index width; image height is 2^Y_BITS.
REQ-003 SHALL have port ap_clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port ap_rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port ap_start, input, 1, frame request, sampled only in IDLE.
REQ-006 SHALL have port ap_idle, output, 1, high while in IDLE.
REQ-007 SHALL have port ap_done, output, 1, one-cycle frame-complete pulse.
REQ-008 SHALL have port s_tdata, input, 8, pixel, raster order.
REQ-009 SHALL have port s_tvalid, input, 1, pixel valid.
REQ-010 SHALL have port s_tready, output, 1, pixel accept.
REQ-011 SHALL have port s_tlast, input, 1, end-of-line marker.
REQ-012 SHALL have port indata_address0, output, X_BITS+Y_BITS, frame-buffer write address {row,col}.
REQ-013 SHALL have ports indata_ce0 and indata_we0, output, 1 each, frame-buffer enable and write enable.
REQ-014 SHALL have port indata_d0, output, 8, frame-buffer write data.
REQ-015 SHALL have port core_start, output, 1, level start to the downstream Sobel core.
REQ-016 SHALL have port core_done, input, 1, core completion (ap_done of the core).
REQ-017 SHALL have port err_tlast, output, 1, sticky line-length error flag.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, RUN and DONE.
REQ-019 IDLE SHALL go to LOAD on ap_start=1, and on that same edge SHALL clear col, row and err_tlast.
REQ-020 In LOAD, s_tready SHALL be 1; in every other state, s_tready SHALL be 0.
REQ-021 A beat SHALL be accepted on s_tvalid&s_tready; indata_ce0, indata_we0, indata_d0=s_tdata and indata_address0={row,col} SHALL be driven combinationally in that same cycle, with zero latency.
REQ-022 On every accepted beat, col SHALL increment; at col=2^X_BITS-1, col SHALL wrap to 0 and row SHALL increment.
REQ-023 When no beat is accepted, indata_ce0 and indata_we0 SHALL be 0, and col and row SHALL hold.
REQ-024 err_tlast SHALL be set when an accepted beat has s_tlast != (col==2^X_BITS-1); the error SHALL NOT alter addressing or flow.
REQ-025 Acceptance of the pixel at row=col=max SHALL move the FSM to RUN, with row and col wrapping to 0.
REQ-026 In RUN, core_start SHALL be 1, held as a level until core_done=1.
REQ-027 core_done=1 in RUN SHALL move the FSM to DONE; core_done in any other state SHALL be ignored.
REQ-028 In DONE, ap_done SHALL be 1 for exactly one cycle, after which the FSM SHALL return to IDLE.
REQ-029 ap_start asserted outside IDLE SHALL be ignored; requests SHALL NOT be queued.
REQ-030 Minimum frame time SHALL be 1 (IDLE) + W*H (LOAD) + core time + 1 (DONE) cycles.

Reset
REQ-031 ap_rst=1 SHALL force IDLE, col=0, row=0 and err_tlast=0 immediately, with no clock edge required.
REQ-032 During reset, all outputs SHALL be 0 except ap_idle, which SHALL be 1.
REQ-033 Reset mid-LOAD or mid-RUN SHALL abandon the frame; frame-buffer contents are not cleared.
REQ-034 On the first edge after reset deassertion, the block SHALL behave as in IDLE.

Verification
REQ-035 Default parameters, ap_start pulse, 262144 beats with s_tvalid=1 and correct s_tlast -> write address 0..0x3FFFF in order, data matching input; core_start rises the cycle after the last beat; err_tlast=0.
REQ-036 X_BITS=2, Y_BITS=1, s_tvalid toggling 1/0 -> 8 writes only on valid cycles; addresses 0,1,2,3,4,5,6,7; no write with we while s_tvalid=0.
REQ-037 In RUN, core_done asserted after 10 cycles -> core_start is 1 for 10 cycles, 0 the next cycle; ap_done=1 for exactly 1 cycle; ap_idle=1 on the following cycle.
REQ-038 X_BITS=2, s_tlast=1 on col=1 of row 0 -> err_tlast=1 and stays 1 through ap_done; the next ap_start clears it.
REQ-039 ap_rst pulsed asynchronously (between clock edges) at beat 3 of LOAD -> s_tready=0 and ap_idle=1 without a clock edge; the next frame writes from address 0.
REQ-040 ap_start held high during LOAD and RUN, plus a spurious core_done in LOAD -> no restart, no early RUN exit; exactly one ap_done per frame.
